// File: rtl/tdm_capture_pkg.sv
// ---------------------------------------------------------------------------
// tdm_capture_pkg
// Shared definitions for the TDM display capture block: capture FSM state
// encoding, digit count, BCD width and the blank anode pattern.
// ---------------------------------------------------------------------------
package tdm_capture_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int BCD_W      = 4;
   localparam int IDX_W      = 3;

   localparam logic [NUM_DIGITS-1:0] ANODE_BLANK = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/tdm_anode_decode.sv
// ---------------------------------------------------------------------------
// tdm_anode_decode
// Combinational classifier for the active-low anode bus.
// Ports:
//   anodes_i  : anode bus, bit i low = digit i+1 driven
//   blank_o   : no digit driven (all ones)
//   valid_o   : exactly one digit driven
//   illegal_o : any other pattern (several digits driven at once)
//   idx_o     : zero-based index of the driven digit, meaningful when valid_o
// ---------------------------------------------------------------------------
module tdm_anode_decode
   import tdm_capture_pkg::*;
(
   input  logic [NUM_DIGITS-1:0] anodes_i,
   output logic                  blank_o,
   output logic                  valid_o,
   output logic                  illegal_o,
   output logic [IDX_W-1:0]      idx_o
);

   logic [NUM_DIGITS-1:0] active;

   assign active = ~anodes_i;

   // A nonzero vector with its lowest set bit cleared becomes zero only when
   // it had a single set bit, which is the one-hot test we need.
   always_comb begin
      blank_o   = (anodes_i == ANODE_BLANK);
      valid_o   = (active != '0) && ((active & (active - 1'b1)) == '0);
      illegal_o = !blank_o && !valid_o;
      idx_o     = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (active[i]) begin
            idx_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/tdm_capture.sv
// ---------------------------------------------------------------------------
// tdm_capture
// Receive side of an 8-digit time-multiplexed display. Watches the anode and
// shared BCD buses, latches each digit once its value has been stable for
// STABLE_CYCLES clocks, pulses frame_strobe when all eight digits have been
// captured since the previous pulse, and flags illegal anode patterns.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   anodos_in        : active-low anode bus
//   bcd_in           : BCD value of the currently driven digit
//   clear_err        : synchronous clear of anode_err (a new error wins)
//   d1..d8           : captured digit values
//   digit_idx        : index of the most recently latched digit
//   frame_strobe     : one-cycle pulse on completion of a full frame
//   anode_err        : sticky illegal-pattern flag
// Optional build macro: TDM_CAPTURE_SYNC_EN inserts a 2-flop synchronizer on
// anodos_in/bcd_in for asynchronous sources (2 extra cycles of latency).
// ---------------------------------------------------------------------------
module tdm_capture
   import tdm_capture_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_DIGITS-1:0] anodos_in,
   input  logic [BCD_W-1:0]      bcd_in,
   input  logic                  clear_err,
   output logic [BCD_W-1:0]      d1,
   output logic [BCD_W-1:0]      d2,
   output logic [BCD_W-1:0]      d3,
   output logic [BCD_W-1:0]      d4,
   output logic [BCD_W-1:0]      d5,
   output logic [BCD_W-1:0]      d6,
   output logic [BCD_W-1:0]      d7,
   output logic [BCD_W-1:0]      d8,
   output logic [IDX_W-1:0]      digit_idx,
   output logic                  frame_strobe,
   output logic                  anode_err
);

   localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
   localparam int SAMPLE_W = NUM_DIGITS + BCD_W;

   logic [NUM_DIGITS-1:0] anodesS;
   logic [BCD_W-1:0]      bcdS;

`ifdef TDM_CAPTURE_SYNC_EN
   logic [SAMPLE_W-1:0] sync1_q;
   logic [SAMPLE_W-1:0] sync2_q;

   // Two-stage synchronizer, idling at the blank pattern so reset never
   // looks like a driven digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= {ANODE_BLANK, {BCD_W{1'b0}}};
         sync2_q <= {ANODE_BLANK, {BCD_W{1'b0}}};
      end else begin
         sync1_q <= {anodos_in, bcd_in};
         sync2_q <= sync1_q;
      end
   end

   assign {anodesS, bcdS} = sync2_q;
`else
   assign anodesS = anodos_in;
   assign bcdS    = bcd_in;
`endif

   logic             isBlank;
   logic             isValid;
   logic             isIllegal;
   logic [IDX_W-1:0] curIdx;

   tdm_anode_decode u_decode (
      .anodes_i  (anodesS),
      .blank_o   (isBlank),
      .valid_o   (isValid),
      .illegal_o (isIllegal),
      .idx_o     (curIdx)
   );

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [SAMPLE_W-1:0]   sample_q;
   logic [NUM_DIGITS-1:0] seen_q, seen_d;
   logic [BCD_W-1:0]      digits_q [NUM_DIGITS];
   logic [IDX_W-1:0]      idx_q;
   logic                  strobe_q, strobe_d;
   logic                  err_q, err_d;

   logic                  sameSample;
   logic                  capture;
   logic [CNT_W-1:0]      cntInc;
   logic [NUM_DIGITS-1:0] seenNext;

   assign sameSample = ({anodesS, bcdS} == sample_q);
   assign cntInc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   // A fresh digit (or a changed value) restarts the count at one; with a
   // single-cycle stability requirement that first sample already captures.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (isIllegal || isBlank) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if ((state_q == IDLE) || !sameSample) begin
         cnt_d = CNT_W'(1);
         if (STABLE_C == CNT_W'(1)) begin
            capture = 1'b1;
            state_d = HOLD;
         end else begin
            state_d = TRACK;
         end
      end else if (state_q == TRACK) begin
         cnt_d = cntInc;
         if (cntInc == STABLE_C) begin
            capture = 1'b1;
            state_d = HOLD;
         end
      end
   end

   // Frame bookkeeping: the capture that completes the set strobes and
   // empties the set on the same edge. New errors take priority over clear.
   always_comb begin
      seenNext = seen_q | (NUM_DIGITS'(1) << curIdx);
      seen_d   = seen_q;
      strobe_d = 1'b0;
      if (capture) begin
         if (seenNext == '1) begin
            seen_d   = '0;
            strobe_d = 1'b1;
         end else begin
            seen_d = seenNext;
         end
      end
      if (isIllegal) begin
         err_d = 1'b1;
      end else if (clear_err) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // State, sample history, captured digits and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sample_q <= {ANODE_BLANK, {BCD_W{1'b0}}};
         seen_q   <= '0;
         idx_q    <= '0;
         strobe_q <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digits_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sample_q <= {anodesS, bcdS};
         seen_q   <= seen_d;
         strobe_q <= strobe_d;
         err_q    <= err_d;
         if (capture) begin
            digits_q[curIdx] <= bcdS;
            idx_q            <= curIdx;
         end
      end
   end

   assign d1           = digits_q[0];
   assign d2           = digits_q[1];
   assign d3           = digits_q[2];
   assign d4           = digits_q[3];
   assign d5           = digits_q[4];
   assign d6           = digits_q[5];
   assign d7           = digits_q[6];
   assign d8           = digits_q[7];
   assign digit_idx    = idx_q;
   assign frame_strobe = strobe_q;
   assign anode_err    = err_q;

endmodule

// File: tb/tb_tdm_capture.sv
// ---------------------------------------------------------------------------
// tb_tdm_capture
// Directed bench for tdm_capture. Inputs change on the falling edge and
// outputs are read on the falling edge. Expected frame contents are queued
// by the stimulus and popped by an independent monitor on each frame_strobe.
// ---------------------------------------------------------------------------
module tb_tdm_capture;

   logic       clk;
   logic       rst_n;
   logic [7:0] anodos;
   logic [3:0] bcd;
   logic       clearErr;
   logic [3:0] d1, d2, d3, d4, d5, d6, d7, d8;
   logic [2:0] digitIdx;
   logic       frameStrobe;
   logic       anodeErr;

   int vectors     = 0;
   int miscompares = 0;
   int strobeCount = 0;

   logic [31:0] expFrames [$];

   tdm_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .anodos_in    (anodos),
      .bcd_in       (bcd),
      .clear_err    (clearErr),
      .d1           (d1),
      .d2           (d2),
      .d3           (d3),
      .d4           (d4),
      .d5           (d5),
      .d6           (d6),
      .d7           (d7),
      .d8           (d8),
      .digit_idx    (digitIdx),
      .frame_strobe (frameStrobe),
      .anode_err    (anodeErr)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] packedDigits();
      return {d8, d7, d6, d5, d4, d3, d2, d1};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
      end
   endtask

   // Drive one input pattern for a number of clock cycles; called at a
   // falling edge and returns at a falling edge.
   task automatic applyStimulus(input logic [7:0] an, input logic [3:0] value,
                                input int cycles);
      anodos = an;
      bcd    = value;
      repeat (cycles) @(negedge clk);
   endtask

   // Scan a run of digits, each held six cycles.
   task automatic scanDigits(input int first, input int last,
                             input logic [31:0] values);
      for (int i = first; i <= last; i++) begin
         logic [7:0] an;
         an = ~(8'b1 << (i - 1));
         applyStimulus(an, values[(i-1)*4 +: 4], 6);
      end
   endtask

   // Monitor: every frame strobe must match a queued expected frame.
   always @(negedge clk) begin
      if (frameStrobe) begin
         strobeCount++;
         if (expFrames.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpectedStrobe: strobe %0d with no frame expected, digits 'h%08h",
                     strobeCount, packedDigits());
         end else begin
            checkOutput("frameDigits", packedDigits(), expFrames.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] scanA;
      logic [31:0] scanB;
      scanA    = 32'h87654321;
      scanB    = 32'h12345678;
      rst_n    = 1'b0;
      anodos   = 8'hFF;
      bcd      = 4'h0;
      clearErr = 1'b0;

      #12;
      checkOutput("resetDigits", packedDigits(), 32'h0);
      checkOutput("resetIdx", 32'(digitIdx), 32'h0);
      checkOutput("resetStrobe", 32'(frameStrobe), 32'h0);
      checkOutput("resetErr", 32'(anodeErr), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] stable digit");
      applyStimulus(8'hFB, 4'd5, 3);
      checkOutput("stableEarly", packedDigits(), 32'h0);
      applyStimulus(8'hFB, 4'd5, 1);
      checkOutput("stableDigits", packedDigits(), 32'h00000500);
      checkOutput("stableIdx", 32'(digitIdx), 32'h2);
      checkOutput("stableErr", 32'(anodeErr), 32'h0);
      applyStimulus(8'hFF, 4'd0, 2);

      $display("[TB] glitch reject");
      applyStimulus(8'hFE, 4'd7, 3);
      applyStimulus(8'hFD, 4'd7, 2);
      applyStimulus(8'hFF, 4'd0, 2);
      checkOutput("glitchDigits", packedDigits(), 32'h00000500);
      checkOutput("glitchIdx", 32'(digitIdx), 32'h2);

      $display("[TB] full scans");
      expFrames.push_back(scanA);
      scanDigits(1, 8, scanA);
      checkOutput("scanAIdx", 32'(digitIdx), 32'h7);
      expFrames.push_back(scanB);
      scanDigits(1, 8, scanB);
      applyStimulus(8'hFF, 4'd0, 2);
      checkOutput("scanStrobes", 32'(strobeCount), 32'd2);

      $display("[TB] illegal patterns");
      applyStimulus(8'hFB, 4'd9, 3);
      applyStimulus(8'hFC, 4'd9, 1);
      checkOutput("illegalErrSet", 32'(anodeErr), 32'h1);
      applyStimulus(8'hFB, 4'd9, 3);
      applyStimulus(8'hFF, 4'd0, 2);
      checkOutput("illegalNoCapture", packedDigits(), scanB);
      checkOutput("errSticky", 32'(anodeErr), 32'h1);
      clearErr = 1'b1;
      applyStimulus(8'hFF, 4'd0, 1);
      checkOutput("errCleared", 32'(anodeErr), 32'h0);
      applyStimulus(8'h00, 4'd0, 1);
      checkOutput("errSetWins", 32'(anodeErr), 32'h1);
      clearErr = 1'b0;
      applyStimulus(8'hFF, 4'd0, 2);
      checkOutput("errHeld", 32'(anodeErr), 32'h1);

      $display("[TB] reset mid-frame");
      scanDigits(1, 5, 32'h000FDCBA);
      checkOutput("partialDigits", packedDigits(), 32'h123FDCBA);
      checkOutput("partialIdx", 32'(digitIdx), 32'h4);
      anodos = 8'hFF;
      bcd    = 4'h0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midResetDigits", packedDigits(), 32'h0);
      checkOutput("midResetIdx", 32'(digitIdx), 32'h0);
      checkOutput("midResetErr", 32'(anodeErr), 32'h0);
      checkOutput("midResetStrobe", 32'(frameStrobe), 32'h0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      scanDigits(6, 8, 32'h87600000);
      applyStimulus(8'hFF, 4'd0, 3);
      checkOutput("postResetDigits", packedDigits(), 32'h87600000);
      checkOutput("postResetIdx", 32'(digitIdx), 32'h7);
      checkOutput("totalStrobes", 32'(strobeCount), 32'd2);
      checkOutput("framesPending", 32'(expFrames.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
